// File: rtl/divsu.sv
// divsu: fixed-point restoring divider, signed or unsigned per operation.
// Fixed latency of WIDTH+FBITS+2 cycles for every non-zero divisor.
module divsu #(
  parameter int WIDTH = 32,
  parameter int FBITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             dbz,
  output logic             ovf,
  output logic [WIDTH-1:0] val
);

  localparam int ITER_N = WIDTH + FBITS;
  localparam int CW     = $clog2(ITER_N + 1);
  localparam int EW     = ITER_N + 1;

  localparam logic [EW-1:0] LIM_U = EW'(1) << WIDTH;
  localparam logic [EW-1:0] LIM_N = EW'(1) << (WIDTH - 1);
  localparam logic [EW-1:0] LIM_P = LIM_N - EW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ITER
  } state_t;

  state_t r_state, w_next;

  logic [WIDTH-1:0]  r_a, r_b, r_d, r_val;
  logic              r_sgn, r_neg;
  logic              r_done, r_valid, r_dbz, r_ovf;
  logic [ITER_N-1:0] r_q;
  logic [WIDTH:0]    r_acc;
  logic [CW-1:0]     r_cnt;

  logic              w_accept, w_zero, w_ge, w_ovf, w_last;
  logic [WIDTH-1:0]  w_ma, w_mb, w_mag, w_res;
  logic [WIDTH:0]    w_sh, w_acc_n;
  logic [ITER_N-1:0] w_q_n;
  logic [EW-1:0]     w_qe;

  assign w_accept = start && (r_state == S_IDLE);
  assign w_zero   = (b == '0);
  assign w_last   = (r_cnt == '0);

  assign w_ma = (r_sgn && r_a[WIDTH-1]) ? -r_a : r_a;
  assign w_mb = (r_sgn && r_b[WIDTH-1]) ? -r_b : r_b;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  assign w_sh    = (r_acc << 1) | {{WIDTH{1'b0}}, r_q[ITER_N-1]};
  assign w_ge    = (w_sh >= {1'b0, r_d});
  assign w_acc_n = w_ge ? (w_sh - {1'b0, r_d}) : w_sh;
  assign w_q_n   = {r_q[ITER_N-2:0], w_ge};

  assign w_qe  = {1'b0, w_q_n};
  assign w_ovf = r_sgn ? (r_neg ? (w_qe > LIM_N) : (w_qe > LIM_P))
                       : (w_qe >= LIM_U);
  assign w_mag = w_q_n[WIDTH-1:0];
  assign w_res = r_neg ? -w_mag : w_mag;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_accept && !w_zero) w_next = S_SETUP;
      end
      S_SETUP: w_next = S_ITER;
      S_ITER:  if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_d     <= '0;
      r_sgn   <= 1'b0;
      r_neg   <= 1'b0;
      r_q     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
      r_val   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_sgn   <= sgn;
        r_valid <= 1'b0;
        r_ovf   <= 1'b0;
        r_val   <= '0;
        r_dbz   <= w_zero;
        r_done  <= w_zero;
      end
      if (r_state == S_SETUP) begin
        r_d   <= w_mb;
        r_q   <= ITER_N'(w_ma) << FBITS;
        r_acc <= '0;
        r_neg <= r_sgn && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
        r_cnt <= CW'(ITER_N - 1);
      end
      if (r_state == S_ITER) begin
        r_acc <= w_acc_n;
        r_q   <= w_q_n;
        r_cnt <= r_cnt - CW'(1);
        // Last step: range check and sign fix fold into the final edge
        if (w_last) begin
          r_done  <= 1'b1;
          r_ovf   <= w_ovf;
          r_valid <= !w_ovf;
          r_val   <= w_ovf ? '0 : w_res;
        end
      end
    end
  end

  assign done  = r_done;
  assign valid = r_valid;
  assign dbz   = r_dbz;
  assign ovf   = r_ovf;
  assign val   = r_val;

endmodule
